// File: rtl/byte_strip_pkg.sv
// Shared definitions for the byte striper/unstriper pair: symbols, FSM encoding
// and the ordered-set symbol test.
package byte_strip_pkg;

  localparam logic [7:0] STP = 8'hfb;
  localparam logic [7:0] SDP = 8'h5c;
  localparam logic [7:0] END = 8'hfd;
  localparam logic [7:0] EDB = 8'hfe;
  localparam logic [7:0] SKP = 8'h1c;
  localparam logic [7:0] IDL = 8'h7c;
  localparam logic [7:0] FTS = 8'h3c;
  localparam logic [7:0] COM = 8'hbc;

  typedef enum logic [0:0] {
    EMPTY  = 1'b0,
    SERIAL = 1'b1
  } state_e;

  // A K-flagged byte that belongs to an ordered set broadcast on every lane.
  function automatic logic is_os_sym(input logic [7:0] b, input logic k);
    logic hit;
    case (b)
      COM, SKP, IDL, FTS: hit = 1'b1;
      default:            hit = 1'b0;
    endcase
    return k & hit;
  endfunction

endpackage

// File: rtl/byte_unstrip_if.sv
// Lane-side and DLL-side handshake bundle of byte_unstrip.
interface byte_unstrip_if;
  logic [7:0] LANE0, LANE1, LANE2, LANE3;
  logic       DK_0, DK_1, DK_2, DK_3;
  logic       LANE_VALID;
  logic       LANE_READY;
  logic [7:0] D;
  logic       DK;
  logic       D_VALID;
  logic       D_READY;
  logic       ERROR_DLL;

  modport slave (
    input  LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3, LANE_VALID, D_READY,
    output LANE_READY, D, DK, D_VALID, ERROR_DLL
  );

  modport master (
    output LANE0, LANE1, LANE2, LANE3, DK_0, DK_1, DK_2, DK_3, LANE_VALID, D_READY,
    input  LANE_READY, D, DK, D_VALID, ERROR_DLL
  );
endinterface

// File: rtl/byte_unstrip_os_classify.sv
// Combinational ordered-set classifier for one 4-lane word: any lane carries an
// OS symbol, and whether all four lanes carry the same OS symbol.
module os_classify
  import byte_strip_pkg::*;
(
  input  logic [3:0][7:0] i_bytes,
  input  logic [3:0]      i_dk,
  output logic            o_uniform_os,
  output logic            o_any_os
);

  logic [3:0] w_os;

  always_comb begin
    w_os = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      w_os[i] = is_os_sym(i_bytes[i], i_dk[i]);
    end
  end

  assign o_any_os     = |w_os;
  assign o_uniform_os = (&w_os) &&
                        (i_bytes[1] == i_bytes[0]) &&
                        (i_bytes[2] == i_bytes[0]) &&
                        (i_bytes[3] == i_bytes[0]);

endmodule

// File: rtl/byte_unstrip.sv
// Re-serializes 4-lane words into a byte stream (lane 0 first).
// Optional feature macro: BYTE_UNSTRIP_OS_COLLAPSE_EN (ordered-set collapse + malformed detection).
module byte_unstrip
  import byte_strip_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET_L,
  byte_unstrip_if.slave bus
);

  state_e          r_state, w_state_nxt;
  logic [1:0]      r_idx, w_idx_nxt;
  logic [1:0]      r_last, w_last_nxt;
  logic [3:0][7:0] r_buf, w_buf_nxt;
  logic [3:0]      r_dk, w_dk_nxt;
  logic            r_err, w_err_nxt;

  logic [3:0][7:0] w_bytes;
  logic [3:0]      w_kin;
  logic            w_out_xfer, w_lane_ready, w_in_xfer, w_store, w_drop;
  logic [1:0]      w_new_last;

  assign w_bytes = {bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0};
  assign w_kin   = {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0};

  assign w_out_xfer   = (r_state == SERIAL) && bus.D_READY;
  assign w_lane_ready = (r_state == EMPTY) || (w_out_xfer && (r_idx == r_last));
  assign w_in_xfer    = bus.LANE_VALID && w_lane_ready;

`ifdef BYTE_UNSTRIP_OS_COLLAPSE_EN
  logic w_uniform_os, w_any_os;

  os_classify u_os_classify (
    .i_bytes      (w_bytes),
    .i_dk         (w_kin),
    .o_uniform_os (w_uniform_os),
    .o_any_os     (w_any_os)
  );

  // A malformed ordered set completes its handshake but is never buffered.
  assign w_drop     = w_any_os && !w_uniform_os;
  assign w_new_last = w_uniform_os ? 2'd0 : 2'd3;
`else
  assign w_drop     = 1'b0;
  assign w_new_last = 2'd3;
`endif

  assign w_store   = w_in_xfer && !w_drop;
  assign w_err_nxt = w_in_xfer && w_drop;

  // Next-state, read index and word buffer.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_last_nxt  = r_last;
    w_buf_nxt   = r_buf;
    w_dk_nxt    = r_dk;
    case (r_state)
      EMPTY: begin
        if (w_store) begin
          w_state_nxt = SERIAL;
          w_idx_nxt   = 2'd0;
          w_last_nxt  = w_new_last;
          w_buf_nxt   = w_bytes;
          w_dk_nxt    = w_kin;
        end else begin
          w_state_nxt = EMPTY;
        end
      end
      SERIAL: begin
        if (w_out_xfer && (r_idx != r_last)) begin
          w_idx_nxt = r_idx + 2'd1;
        end else if (w_out_xfer && w_store) begin
          w_idx_nxt  = 2'd0;
          w_last_nxt = w_new_last;
          w_buf_nxt  = w_bytes;
          w_dk_nxt   = w_kin;
        end else if (w_out_xfer) begin
          w_state_nxt = EMPTY;
          w_idx_nxt   = 2'd0;
        end else begin
          w_state_nxt = SERIAL;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
        w_idx_nxt   = 2'd0;
      end
    endcase
  end

  // State, buffer and error-pulse registers.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= EMPTY;
      r_idx   <= 2'd0;
      r_last  <= 2'd3;
      r_buf   <= '0;
      r_dk    <= 4'b0000;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_buf   <= w_buf_nxt;
      r_dk    <= w_dk_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign bus.LANE_READY = w_lane_ready;
  assign bus.D_VALID    = (r_state == SERIAL);
  assign bus.D          = (r_state == SERIAL) ? r_buf[r_idx] : 8'h00;
  assign bus.DK         = (r_state == SERIAL) ? r_dk[r_idx] : 1'b0;
  assign bus.ERROR_DLL  = r_err;

endmodule

// File: tb/tb_byte_unstrip.sv
// Randomized + directed bench for byte_unstrip against a byte-queue reference model.
module tb_byte_unstrip;

  logic clk = 1'b0;
  logic rst_l;
  int   n_checks = 0;
  int   n_fail   = 0;

  byte_unstrip_if bus ();

  byte_unstrip dut (
    .CLK     (clk),
    .RESET_L (rst_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bytes still owed to the DLL, and the pending error pulse.
  logic [8:0] exp_q[$];
  logic       exp_err = 1'b0;
  logic       acc     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic os_sym(input logic [7:0] b, input logic k);
    return k && (b == 8'hbc || b == 8'h1c || b == 8'h7c || b == 8'h3c);
  endfunction

  // Number of bytes a stored word yields, or 0 when the word is dropped as malformed.
  function automatic int word_len(input logic [31:0] w, input logic [3:0] k);
    int  n_os = 0;
    logic same = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (os_sym(w[8*i +: 8], k[i])) n_os++;
      if (w[8*i +: 8] != w[7:0]) same = 1'b0;
    end
`ifdef BYTE_UNSTRIP_OS_COLLAPSE_EN
    if (n_os == 4 && same) return 1;
    if (n_os > 0) return 0;
`endif
    return 4;
  endfunction

  // Drive one cycle (called just after a falling edge), check outputs, advance the model.
  task automatic step(input logic v, input logic [31:0] w, input logic [3:0] k, input logic rdy);
    logic exp_lr, out_x;
    int   n;
    bus.LANE_VALID = v;
    {bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0} = w;
    {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0} = k;
    bus.D_READY = rdy;
    #1;
    out_x  = (exp_q.size() > 0) && rdy;
    exp_lr = (exp_q.size() == 0) || (exp_q.size() == 1 && rdy);
    chk("d_valid", bus.D_VALID, exp_q.size() > 0);
    chk("lane_ready", bus.LANE_READY, exp_lr);
    chk("error_dll", bus.ERROR_DLL, exp_err);
    if (exp_q.size() > 0) chk("d_dk", {bus.DK, bus.D}, exp_q[0]);
    if (out_x) void'(exp_q.pop_front());
    acc     = v && exp_lr;
    n       = acc ? word_len(w, k) : 0;
    exp_err = acc && (n == 0);
    for (int i = 0; i < n; i++) exp_q.push_back({k[i], w[8*i +: 8]});
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    rst_l = 1'b0;
    #1;
    chk({tag, "_dvalid"}, bus.D_VALID, 1'b0);
    chk({tag, "_d"}, bus.D, 8'h00);
    chk({tag, "_dk"}, bus.DK, 1'b0);
    chk({tag, "_err"}, bus.ERROR_DLL, 1'b0);
    chk({tag, "_lready"}, bus.LANE_READY, 1'b1);
    exp_q.delete();
    exp_err = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  function automatic logic [31:0] rand_word(input int kind, output logic [3:0] k);
    logic [7:0]  os_tab [4] = '{8'hbc, 8'h1c, 8'h7c, 8'h3c};
    logic [7:0]  s;
    logic [31:0] w;
    w = $urandom();
    k = 4'b0000;
    s = os_tab[$urandom_range(0, 3)];
    case (kind)
      1: begin w = {4{s}}; k = 4'b1111; end
      2: begin w[8*$urandom_range(0, 3) +: 8] = s; k = 4'($urandom()) | 4'b0001; w[7:0] = s; end
      3: k = 4'($urandom());
      default: k = 4'b0000;
    endcase
    return w;
  endfunction

  initial begin
    logic        v, hold, rdy;
    logic [31:0] w;
    logic [3:0]  k;
    rst_l = 1'b0;
    bus.LANE_VALID = 1'b0;
    bus.D_READY = 1'b1;
    {bus.LANE3, bus.LANE2, bus.LANE1, bus.LANE0} = 32'h0;
    {bus.DK_3, bus.DK_2, bus.DK_1, bus.DK_0} = 4'b0000;
    @(negedge clk);
    reset_check("por");

    // Data word then back-to-back words with valid held high.
    step(1'b1, 32'h44332211, 4'b0000, 1'b1);
    step(1'b1, 32'h88776655, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'hccbbaa99, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 4'b0000, 1'b1);

    // Uniform SKP quad, malformed COM, then a normal word.
    step(1'b1, 32'h1c1c1c1c, 4'b1111, 1'b1);
    step(1'b0, 32'h0, 4'b0000, 1'b1);
    step(1'b1, 32'h000000bc, 4'b0001, 1'b1);
    step(1'b1, 32'h000000bc, 4'b0001, 1'b1);
    step(1'b1, 32'hd4c3b2a1, 4'b0000, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 4'b0000, 1'b1);

    // Backpressure for 3 cycles while the second byte is on D.
    step(1'b1, 32'h44332211, 4'b0000, 1'b1);
    step(1'b0, 32'h0, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h55555555, 4'b0000, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 4'b0000, 1'b1);

    // Reset while the third byte is on D; next word starts at lane 0.
    step(1'b1, 32'h44332211, 4'b0000, 1'b1);
    step(1'b0, 32'h0, 4'b0000, 1'b1);
    step(1'b0, 32'h0, 4'b0000, 1'b1);
    reset_check("mid");
    step(1'b1, 32'h0d0c0b0a, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 4'b0000, 1'b1);

    // Random traffic; the source holds an unaccepted word.
    hold = 1'b0;
    v = 1'b0;
    w = 32'h0;
    k = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        v = ($urandom_range(0, 3) != 0);
        w = rand_word($urandom_range(0, 5), k);
      end
      rdy = ($urandom_range(0, 4) != 0);
      step(v, w, k, rdy);
      hold = v && !acc;
      if (c % 700 == 699) begin
        reset_check("rnd");
        hold = 1'b0;
      end
    end
    for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 4'b0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_unstrip.md
# byte_unstrip

Receive-side counterpart of `byte_strip`. The block accepts one 4-lane word per handshake (LANE0..LANE3, each with its K-flag) and re-serializes it into a single byte stream in lane order 0,1,2,3. When enabled, it collapses ordered-set symbols that the striper broadcast to all lanes back into a single byte, and it flags malformed ordered sets to the DLL. It sits between the lane deskew stage and the DLL byte interface.

## Interface
- `COM`, 8'hbc, comma ordered-set symbol
- `SKP`, 8'h1c, skip ordered-set symbol
- `IDL`, 8'h7c, idle ordered-set symbol
- `FTS`, 8'h3c, fast-training ordered-set symbol
- `CLK`  in  1  single clock; all state changes on rising edge
- `RESET_L`  in  1  reset, asynchronous, active-low
- `LANE0`..`LANE3`  in  8 each  lane bytes of the incoming word
- `DK_0`..`DK_3`  in  1 each  K-flag per lane
- `LANE_VALID`  in  1  input word present
- `LANE_READY`  out  1  block can accept a word this cycle
- `D`  out  8  serialized byte
- `DK`  out  1  K-flag of `D`
- `D_VALID`  out  1  `D`/`DK` valid
- `D_READY`  in  1  downstream accepts `D` this cycle
- `ERROR_DLL`  out  1  one-cycle pulse: malformed ordered set, word dropped

## Operation
- Word buffer: 4 bytes + 4 DK bits, a 2-bit read index `idx`, and a 2-bit `last` (index of the final byte to emit).
- States:
  - EMPTY: `D_VALID`=0.
  - SERIAL: `D_VALID`=1; `D`/`DK` come from buffer[`idx`].
- Transfers: input transfer = `LANE_VALID && LANE_READY`; output transfer = `D_VALID && D_READY`.
- `LANE_READY` = (state==EMPTY) || (output transfer && `idx`==`last`). It is combinational and allows back-to-back words with no bubble.
- Transitions:
  - EMPTY + input transfer (word stored) -> SERIAL, `idx`=0.
  - SERIAL + output transfer with `idx`!=`last` -> `idx`+1.
  - SERIAL + output transfer with `idx`==`last` -> SERIAL with `idx`=0 if a new word is stored in the same cycle, else EMPTY.
- Normal word: `last`=3; output order is LANE0, LANE1, LANE2, LANE3.
- Ordered-set handling (macro on):
  - OS symbol = byte in {COM,SKP,IDL,FTS} with DK=1.
  - Uniform quad: all four lanes carry the same OS symbol with DK=1. The word is stored with `last`=0, so one byte is emitted.
  - Malformed: any lane carries an OS symbol but the quad is not uniform. The word is accepted (handshake completes) but not stored. `ERROR_DLL`=1 for the next cycle and the state is unchanged by that word.
- `D_READY` low holds `D`, `DK`, `D_VALID` and `idx` stable.

## Timing
- Reset (`RESET_L`=0, takes effect immediately):
  - state EMPTY, `idx`=0, buffer cleared.
  - `D`=0, `DK`=0, `D_VALID`=0, `ERROR_DLL`=0; `LANE_READY`=1 (input ignored while in reset).
- Latency: word accepted at edge N -> LANE0 byte on `D` after edge N (visible cycle N+1). With `D_READY` held high, lane k appears in cycle N+1+k.
- Throughput: 1 byte/cycle. A new word is accepted on the same edge that consumes the last byte.
- `ERROR_DLL`: registered, high exactly one cycle after the malformed word's accept edge. Back-to-back malformed words produce back-to-back pulses.
- Reset mid-word: the buffered word is discarded. No partial word is replayed after release.
- `LANE_VALID` without `LANE_READY`: the word must be held by the source. The block does not sample it.

## Configuration
- `BYTE_UNSTRIP_OS_COLLAPSE_EN` defined: ordered-set collapse and malformed detection as above.
- `BYTE_UNSTRIP_OS_COLLAPSE_EN` undefined:
  - Every word is emitted as 4 bytes verbatim (`last`=3 always).
  - `ERROR_DLL` is tied 0 and no word is dropped.

## Structure
- Shared package `byte_strip_pkg`:
  - symbol constants STP, SDP, END, EDB, SKP, IDL, FTS, COM.
  - state encoding (EMPTY, SERIAL).
- Sub-module `os_classify`: combinational; takes the 4 bytes and 4 DK bits.
  - outputs `uniform_os`, `any_os`.
  - instantiated only under the macro.

## Test plan
- Data word: LANE0..3 = 8'h11,8'h22,8'h33,8'h44, DK=0, `D_READY`=1 -> `D` = 11,22,33,44 in cycles N+1..N+4, DK=0, no gaps.
- Back-to-back words with `LANE_VALID` held high -> `LANE_READY` high every 4th cycle, continuous `D_VALID`, 8 bytes in order.
- Uniform SKP quad (1c×4, DK=1111), macro on -> single byte 8'h1c, DK=1. `LANE_READY` returns high one cycle later. Macro off -> four 8'h1c bytes.
- Malformed: LANE0=COM DK=1, LANE1..3 = 8'h00 DK=0, macro on -> no `D_VALID`, `ERROR_DLL` pulse for 1 cycle at N+1, next word serialized normally.
- Backpressure: `D_READY` low for 3 cycles while `idx`=1 -> `D`=LANE1 byte held stable, `LANE_READY`=0, resumes at LANE1 with no loss.
- `RESET_L` asserted while `idx`=2 -> `D_VALID`,`D`,`DK` zero immediately. After release the block is EMPTY and the next word starts at LANE0.
